kyber_red_out_buffer: RTL and testbench

//   Sits directly downstream of the 3-stage Kyber reduction pipeline, which cannot stall. Buffers its

---
 rtl/kyber_red_out_buffer.sv | 97 +++++++++
 tb/tb_kyber_red_out_buffer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/kyber_red_out_buffer.sv
// Output FIFO behind the non-stallable Kyber reduction pipeline.
// Start-of-reduction is credit-gated so a returning result always finds a free slot.
module kyber_red_out_buffer #(
  parameter int DATA_W   = 12,
  parameter int DEPTH    = 8,
  parameter int PIPE_LAT = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       issue_i,
  output logic                       issue_ready_o,
  input  logic                       red_valid_i,
  input  logic [23:0]                red_result_i,
  output logic [DATA_W-1:0]          coeff_o,
  output logic                       coeff_valid_o,
  input  logic                       coeff_ready_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic [$clog2(DEPTH+1)-1:0] inflight_o,
  output logic                       err_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  // Credits never depend on the pipeline latency; it only has to be a real pipeline.
  if (DEPTH < 2 || PIPE_LAT < 1) begin : g_bad_param
    $error("kyber_red_out_buffer: DEPTH must be >= 2 and PIPE_LAT >= 1");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [CW-1:0]     inflight;
  logic [CW:0]       occupancy;
  logic              err;

  logic issue_ok;
  logic ret;
  logic stale;
  logic pop;
  logic wide;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    else                     return p + PW'(1);
  endfunction

  assign occupancy     = {1'b0, count} + {1'b0, inflight};
  assign issue_ready_o = occupancy < (CW + 1)'(DEPTH);

  assign issue_ok = issue_i & issue_ready_o;
  assign ret      = red_valid_i & (inflight != '0);
  assign stale    = red_valid_i & (inflight == '0);
  assign pop      = (count != '0) & coeff_ready_i;
  assign wide     = |red_result_i[23:DATA_W];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      inflight <= '0;
      err      <= 1'b0;
    end else begin
      case ({issue_ok, ret})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase

      case ({ret, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      if (ret) wr_ptr <= ptr_next(wr_ptr);
      if (pop) rd_ptr <= ptr_next(rd_ptr);

      // Sticky: over-issue, orphan result, or a result that does not fit DATA_W.
      if ((issue_i & ~issue_ready_o) | stale | (ret & wide)) err <= 1'b1;
    end
  end

  // Storage needs no reset; count gates visibility of every entry.
  always_ff @(posedge clk_i) begin
    if (ret) mem[wr_ptr] <= red_result_i[DATA_W-1:0];
  end

  assign coeff_o       = mem[rd_ptr];
  assign coeff_valid_o = (count != '0);
  assign count_o       = count;
  assign inflight_o    = inflight;
  assign err_o         = err;

endmodule

// File: tb/tb_kyber_red_out_buffer.sv
// Directed bench for kyber_red_out_buffer with a 3-stage pipeline model and an
// issue-order scoreboard checked on every pop.
module tb_kyber_red_out_buffer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        issue_i;
  logic        issue_ready_o;
  logic        red_valid_i;
  logic [23:0] red_result_i;
  logic [11:0] coeff_o;
  logic        coeff_valid_o;
  logic        coeff_ready_i;
  logic [3:0]  count_o;
  logic [3:0]  inflight_o;
  logic        err_o;

  kyber_red_out_buffer #(.DATA_W(12), .DEPTH(8), .PIPE_LAT(3)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .issue_i       (issue_i),
    .issue_ready_o (issue_ready_o),
    .red_valid_i   (red_valid_i),
    .red_result_i  (red_result_i),
    .coeff_o       (coeff_o),
    .coeff_valid_o (coeff_valid_o),
    .coeff_ready_i (coeff_ready_i),
    .count_o       (count_o),
    .inflight_o    (inflight_o),
    .err_o         (err_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned n_acc = 0;
  bit          auto_pipe = 1'b0;
  logic [2:0]  pv;
  logic [23:0] pd [3];
  logic [11:0] tag = 12'h100;
  logic [11:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // One clock: check any pop against the scoreboard, then advance the pipeline model.
  task automatic step();
    bit acc;
    bit pop;
    acc = issue_i && issue_ready_o;
    pop = coeff_valid_o && coeff_ready_i;
    if (pop) begin
      if (exp_q.size() == 0) chk("pop_extra", 32'd1, 32'd0);
      else                   chk("pop_order", 32'(coeff_o), 32'(exp_q.pop_front()));
    end
    if (acc) n_acc++;
    @(posedge clk_i);
    #1;
    if (auto_pipe) begin
      pd[2] = pd[1];
      pd[1] = pd[0];
      pv    = {pv[1:0], acc};
      if (acc) begin
        pd[0] = {12'h000, tag};
        exp_q.push_back(tag);
        tag = tag + 12'h011;
      end else begin
        pd[0] = 24'h0;
      end
      red_valid_i  = pv[2];
      red_result_i = pd[2];
    end
  endtask

  task automatic do_reset(input int cycles);
    rst_i = 1'b1;
    repeat (cycles) begin
      issue_i       = 1'($urandom_range(0, 1));
      red_valid_i   = 1'($urandom_range(0, 1));
      red_result_i  = 24'($urandom);
      coeff_ready_i = 1'($urandom_range(0, 1));
      @(posedge clk_i);
      #1;
    end
    rst_i         = 1'b0;
    issue_i       = 1'b0;
    red_valid_i   = 1'b0;
    red_result_i  = 24'h0;
    coeff_ready_i = 1'b0;
    pv            = '0;
    pd[0]         = 24'h0;
    pd[1]         = 24'h0;
    pd[2]         = 24'h0;
    exp_q.delete();
    n_acc         = 0;
  endtask

  task automatic fill_to_credit(input string name);
    for (int i = 0; i < 20; i++) begin
      issue_i = issue_ready_o;
      step();
    end
    issue_i = 1'b0;
    chk({name, "_accepted"}, n_acc, 32'd8);
    chk({name, "_ready_low"}, 32'(issue_ready_o), 32'd0);
    chk({name, "_err_clean"}, 32'(err_o), 32'd0);
    chk({name, "_count_full"}, 32'(count_o), 32'd8);
  endtask

  task automatic drain(input string name);
    int k;
    coeff_ready_i = 1'b1;
    k = 0;
    while (coeff_valid_o && k < 20) begin
      step();
      k++;
    end
    chk({name, "_drained"}, 32'(count_o), 32'd0);
    chk({name, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    coeff_ready_i = 1'b0;
  endtask

  initial begin
    logic [11:0] v4;
    int k;

    // 1: reset with random inputs
    do_reset(2);
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_inflight", 32'(inflight_o), 32'd0);
    chk("rst_valid", 32'(coeff_valid_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_ready", 32'(issue_ready_o), 32'd1);

    // 2: single issue, manual return at cycle 3
    auto_pipe = 1'b0;
    issue_i = 1'b1;
    step();
    issue_i = 1'b0;
    chk("t2_inflight_c1", 32'(inflight_o), 32'd1);
    step();
    chk("t2_inflight_c2", 32'(inflight_o), 32'd1);
    step();
    chk("t2_inflight_c3", 32'(inflight_o), 32'd1);
    red_valid_i  = 1'b1;
    red_result_i = 24'h000ABC;
    exp_q.push_back(12'hABC);
    step();
    red_valid_i = 1'b0;
    chk("t2_valid_c4", 32'(coeff_valid_o), 32'd1);
    chk("t2_coeff_c4", 32'(coeff_o), 32'hABC);
    chk("t2_inflight_c4", 32'(inflight_o), 32'd0);
    coeff_ready_i = 1'b1;
    step();
    coeff_ready_i = 1'b0;
    chk("t2_empty", 32'(coeff_valid_o), 32'd0);
    chk("t2_err", 32'(err_o), 32'd0);

    // 3: credit limit with stalled consumer, then ordered drain
    do_reset(1);
    auto_pipe = 1'b1;
    fill_to_credit("t3");
    issue_i = 1'b1;
    step();
    issue_i = 1'b0;
    chk("t3_overissue_err", 32'(err_o), 32'd1);
    chk("t3_overissue_inflight", 32'(inflight_o), 32'd0);
    drain("t3");

    // 4: simultaneous push and pop at count 3
    do_reset(1);
    issue_i = 1'b1;
    repeat (4) step();
    issue_i = 1'b0;
    k = 0;
    while (!(count_o == 4'd3 && red_valid_i) && k < 10) begin
      step();
      k++;
    end
    chk("t4_reach_cnt3", 32'(k < 10), 32'd1);
    v4 = (exp_q.size() == 4) ? exp_q[3] : 12'h000;
    coeff_ready_i = 1'b1;
    step();
    chk("t4_count_hold", 32'(count_o), 32'd3);
    step();
    step();
    chk("t4_new_head_valid", 32'(coeff_valid_o), 32'd1);
    chk("t4_new_head", 32'(coeff_o), 32'(v4));
    drain("t4");
    chk("t4_err", 32'(err_o), 32'd0);

    // 5a: orphan result
    do_reset(1);
    auto_pipe = 1'b0;
    red_valid_i  = 1'b1;
    red_result_i = 24'h000123;
    step();
    red_valid_i = 1'b0;
    chk("t5a_not_pushed", 32'(count_o), 32'd0);
    chk("t5a_valid", 32'(coeff_valid_o), 32'd0);
    chk("t5a_err", 32'(err_o), 32'd1);
    repeat (3) step();
    chk("t5a_err_sticky", 32'(err_o), 32'd1);

    // 5b: oversized result is truncated and flagged
    do_reset(1);
    chk("t5b_err_cleared", 32'(err_o), 32'd0);
    issue_i = 1'b1;
    step();
    issue_i = 1'b0;
    red_valid_i  = 1'b1;
    red_result_i = 24'h010005;
    step();
    red_valid_i = 1'b0;
    chk("t5b_valid", 32'(coeff_valid_o), 32'd1);
    chk("t5b_coeff", 32'(coeff_o), 32'h005);
    chk("t5b_err", 32'(err_o), 32'd1);

    // 6: reset with 5 stored and 2 in flight
    do_reset(1);
    auto_pipe = 1'b1;
    issue_i = 1'b1;
    repeat (7) step();
    issue_i = 1'b0;
    k = 0;
    while (count_o != 4'd5 && k < 10) begin
      step();
      k++;
    end
    chk("t6_stored5", 32'(count_o), 32'd5);
    chk("t6_inflight2", 32'(inflight_o), 32'd2);
    do_reset(1);
    chk("t6_count", 32'(count_o), 32'd0);
    chk("t6_inflight", 32'(inflight_o), 32'd0);
    chk("t6_valid", 32'(coeff_valid_o), 32'd0);
    chk("t6_ready", 32'(issue_ready_o), 32'd1);
    fill_to_credit("t6");
    drain("t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
